// File: rtl/oai22_gate.sv
// OAI22 cell: combinational ~((in0|in1)&(in2|in3)), a registered copy of the
// output, and a saturating count of cycles on which the output was low.
module oai22_gate #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in0,
    input  logic             in1,
    input  logic             in2,
    input  logic             in3,
    output logic             out,
    output logic             out_q,
    output logic [CNT_W-1:0] low_cnt
);

    logic             out_q_d;
    logic             out_q_q;
    logic [CNT_W-1:0] low_cnt_d;
    logic [CNT_W-1:0] low_cnt_q;

    // Pure function of the inputs; deliberately independent of reset and state.
    assign out = ~((in0 | in1) & (in2 | in3));

    always_comb begin
        out_q_d   = out;
        low_cnt_d = low_cnt_q;
        if (!out && (low_cnt_q != '1)) begin
            low_cnt_d = low_cnt_q + CNT_W'(1);
        end
    end

    // Reset value of out_q matches the OAI22 result for all-zero inputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_q_q   <= 1'b1;
            low_cnt_q <= '0;
        end else begin
            out_q_q   <= out_q_d;
            low_cnt_q <= low_cnt_d;
        end
    end

    assign out_q   = out_q_q;
    assign low_cnt = low_cnt_q;

endmodule

// File: tb/tb_oai22_gate.sv
// Directed-vector bench for oai22_gate with a queue-based scoreboard; a second
// instance built with a 3-bit counter shares the stimulus to exercise saturation.
module tb_oai22_gate;

    logic        clk;
    logic        reset;
    logic        in0, in1, in2, in3;
    logic        out_w, out_q_w;
    logic [15:0] low_cnt_w;
    logic        out_s, out_q_s;
    logic [2:0]  low_cnt_s;

    int checks;
    int errors;

    typedef struct {
        logic exp_out;
        logic chk_q;
        logic exp_q;
        logic chk_c;
        int   exp_c;
        logic chk_s;
        int   exp_s;
        int   row;
    } exp_t;

    exp_t sb[$];
    int   row_n;
    logic stim_done;

    oai22_gate #(.CNT_W(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .in0     (in0),
        .in1     (in1),
        .in2     (in2),
        .in3     (in3),
        .out     (out_w),
        .out_q   (out_q_w),
        .low_cnt (low_cnt_w)
    );

    oai22_gate #(.CNT_W(3)) dut_sat (
        .clk     (clk),
        .reset   (reset),
        .in0     (in0),
        .in1     (in1),
        .in2     (in2),
        .in3     (in3),
        .out     (out_s),
        .out_q   (out_q_s),
        .low_cnt (low_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one row just after the rising edge; expectations apply at the
    // following falling edge, where registered outputs show the previous row.
    task automatic drive_row(input logic rst, input logic [3:0] v,
                             input logic eo,
                             input logic cq, input logic eq,
                             input logic cc, input int ec,
                             input logic cs, input int es);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst;
        {in0, in1, in2, in3} = v;
        e.exp_out = eo;
        e.chk_q = cq;  e.exp_q = eq;
        e.chk_c = cc;  e.exp_c = ec;
        e.chk_s = cs;  e.exp_s = es;
        e.row = row_n;
        row_n++;
        sb.push_back(e);
    endtask

    // Monitor: outputs are presented every cycle, sampled mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (out_w !== e.exp_out) begin
                    errors++;
                    $display("FAIL out row %0d: got %b expected %b", e.row, out_w, e.exp_out);
                end
                checks++;
                if (out_s !== e.exp_out) begin
                    errors++;
                    $display("FAIL out_sat row %0d: got %b expected %b", e.row, out_s, e.exp_out);
                end
                if (e.chk_q) begin
                    checks++;
                    if (out_q_w !== e.exp_q) begin
                        errors++;
                        $display("FAIL out_q row %0d: got %b expected %b", e.row, out_q_w, e.exp_q);
                    end
                end
                if (e.chk_c) begin
                    checks++;
                    if (int'(low_cnt_w) !== e.exp_c) begin
                        errors++;
                        $display("FAIL low_cnt row %0d: got %0d expected %0d", e.row, low_cnt_w, e.exp_c);
                    end
                end
                if (e.chk_s) begin
                    checks++;
                    if (int'(low_cnt_s) !== e.exp_s) begin
                        errors++;
                        $display("FAIL low_cnt_sat row %0d: got %0d expected %0d", e.row, low_cnt_s, e.exp_s);
                    end
                end
            end
        end
    end

    initial begin
        logic [15:0] tt_one;
        logic [3:0]  v;
        checks = 0;
        errors = 0;
        row_n = 0;
        stim_done = 1'b0;
        reset = 1'b0;
        {in0, in1, in2, in3} = 4'b0000;
        // Rows where out = 1: 0000,0001,0010,0011,0100,1000,1100.
        tt_one = 16'h111F;

        // Row 0: reset state.
        drive_row(1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b1, 0);

        // Rows 1-16: exhaustive truth table.
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            drive_row(1'b1, v, tt_one[i], 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
        end

        // Registered copy: 0101 then 0000.
        drive_row(1'b1, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
        drive_row(1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
        drive_row(1'b1, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 0);

        // Counter accumulation: reset, 1111 x5, 0000 x3.
        drive_row(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
        drive_row(1'b1, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b1, 0);
        drive_row(1'b1, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b0, 0);
        drive_row(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0, 0);
        drive_row(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b0, 0);
        drive_row(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b0, 0);
        drive_row(1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 5, 1'b1, 5);
        drive_row(1'b1, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 5, 1'b0, 0);
        drive_row(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 5, 1'b0, 0);

        // Reset mid-run with out low: reset wins over counting on that edge.
        drive_row(1'b0, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b1, 5, 1'b0, 0);
        drive_row(1'b1, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b1, 0);
        drive_row(1'b1, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b1, 1);

        // Saturation of the 3-bit counter while 1111 is held.
        drive_row(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 2);
        drive_row(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
        drive_row(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
        drive_row(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
        drive_row(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1, 6, 1'b1, 6);
        drive_row(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1, 7, 1'b1, 7);
        drive_row(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 7);
        drive_row(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
        drive_row(1'b1, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b1, 10, 1'b1, 7);

        // Let the monitor drain, bounded.
        for (int k = 0; k < 5 && sb.size() > 0; k++) @(posedge clk);
        @(posedge clk);
        stim_done = 1'b1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish by 20000");
        $fatal(1, "timeout");
    end

endmodule
